sn_chan_mixer: RTL

Parametrised, time-multiplexed PSG channel mixer for the Konami sound boards. It replaces per-chip hard-wired filter instances with one sequential datapath. Each sample strobe, it takes `NUM_CH` unsigned PSG outputs through:

- optional DC removal,
- three one-pole low-pass filters per channel (light/medium/heavy), with the mode selected per channel,
- a summing accumulator,
- a gain stage with saturation.

It sits between the SN76489 instances and the board-level `sound` output.

---
 rtl/sn_chan_mixer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/sn_chan_mixer.sv
// Time-multiplexed PSG channel mixer: optional DC removal (SND_DCRM_EN), three one-pole low-passes
// per channel, summing accumulator and saturating gain; one channel per clk_14m cycle after sample_en.
module sn_chan_mixer #(
  parameter int NUM_CH   = 3,
  parameter int IN_W     = 8,
  parameter int OUT_W    = 16,
  parameter int GAIN     = 176,
  parameter int SH_LIGHT = 3,
  parameter int SH_MED   = 5,
  parameter int SH_HEAVY = 6,
  parameter int DCRM_SH  = 10
) (
  input  logic                     clk_14m,
  input  logic                     n_reset,
  input  logic                     sample_en,
  input  logic [NUM_CH*IN_W-1:0]   ch_in,
  input  logic [2*NUM_CH-1:0]      ch_mode,
  output logic [OUT_W-1:0]         sound,
  output logic                     sound_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam int X_W   = IN_W + 1;
  localparam int Y_W   = IN_W + 9;
  localparam int ACC_W = IN_W + 2 + $clog2(NUM_CH);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int P_W   = ACC_W + 11;
  localparam logic [9:0] GAIN_U = GAIN[9:0];
  localparam logic signed [P_W-1:0] P_MAX = {{(P_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [P_W-1:0] P_MIN = {{(P_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  if (NUM_CH < 1 || NUM_CH > 8 || DCRM_SH < 1 || GAIN > 1023 || P_W <= OUT_W) begin : g_bad_cfg
    $error("sn_chan_mixer: unsupported parameter set");
  end

  typedef enum logic [1:0] {IDLE, PROC, MIX} state_t;

  state_t                   state, state_nx;
  logic [NUM_CH*IN_W-1:0]   snap_in;
  logic [2*NUM_CH-1:0]      snap_mode;
  logic [IDX_W-1:0]         idx;
  logic signed [ACC_W-1:0]  acc;
  logic signed [Y_W-1:0]    yl [NUM_CH];
  logic signed [Y_W-1:0]    ym [NUM_CH];
  logic signed [Y_W-1:0]    yh [NUM_CH];
`ifdef SND_DCRM_EN
  logic signed [Y_W-1:0]    dc [NUM_CH];
  logic signed [Y_W-1:0]    dc_nx;
`endif

  logic [IN_W-1:0]          cur_in;
  logic [1:0]               cur_mode;
  logic signed [X_W-1:0]    x;
  logic signed [X_W-1:0]    cval;
  logic signed [Y_W-1:0]    yl_nx, ym_nx, yh_nx;
  logic signed [ACC_W-1:0]  contrib;
  logic signed [P_W-1:0]    acc_x, gain_x, prod;
  logic [OUT_W-1:0]         sat;

  // y + ((tgt - y) >>> sh), evaluated one bit wider so the difference cannot wrap
  function automatic logic signed [Y_W-1:0] lp(input logic signed [Y_W-1:0] y,
                                               input logic signed [Y_W:0] tgt,
                                               input int sh);
    logic signed [Y_W:0] ye, diff, sum;
    ye   = {y[Y_W-1], y};
    diff = tgt - ye;
    sum  = ye + (diff >>> sh);
    return sum[Y_W-1:0];
  endfunction

  assign busy = (state != IDLE);

  always_ff @(posedge clk_14m) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sample_en) state_nx = PROC;
      PROC:    if (idx == IDX_W'(NUM_CH - 1)) state_nx = MIX;
      MIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cur_in   = snap_in[idx*IN_W +: IN_W];
    cur_mode = snap_mode[idx*2 +: 2];
`ifdef SND_DCRM_EN
    x     = $signed({1'b0, cur_in}) - $signed(dc[idx][Y_W-1:8]);
    dc_nx = lp(dc[idx], {2'b00, cur_in, 8'b0}, DCRM_SH);
`else
    x     = $signed({1'b0, cur_in});
`endif
    yl_nx = lp(yl[idx], {x[X_W-1], x, 8'b0}, SH_LIGHT);
    ym_nx = lp(ym[idx], {x[X_W-1], x, 8'b0}, SH_MED);
    yh_nx = lp(yh[idx], {x[X_W-1], x, 8'b0}, SH_HEAVY);
    case (cur_mode)
      2'b01:   cval = yl_nx[Y_W-1:8];
      2'b10:   cval = ym_nx[Y_W-1:8];
      2'b11:   cval = yh_nx[Y_W-1:8];
      default: cval = x;
    endcase
    contrib = {{(ACC_W-X_W){cval[X_W-1]}}, cval};
    acc_x   = {{(P_W-ACC_W){acc[ACC_W-1]}}, acc};
    gain_x  = {{(P_W-10){1'b0}}, GAIN_U};
    prod    = acc_x * gain_x;
    if (prod > P_MAX)      sat = P_MAX[OUT_W-1:0];
    else if (prod < P_MIN) sat = P_MIN[OUT_W-1:0];
    else                   sat = prod[OUT_W-1:0];
  end

  always_ff @(posedge clk_14m) begin
    if (!n_reset) begin
      snap_in     <= '0;
      snap_mode   <= '0;
      idx         <= '0;
      acc         <= '0;
      sound       <= '0;
      sound_valid <= 1'b0;
      overrun     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        yl[i] <= '0;
        ym[i] <= '0;
        yh[i] <= '0;
`ifdef SND_DCRM_EN
        dc[i] <= '0;
`endif
      end
    end else begin
      sound_valid <= 1'b0;
      if (sample_en && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (sample_en) begin
            snap_in   <= ch_in;
            snap_mode <= ch_mode;
            acc       <= '0;
            idx       <= '0;
          end
        end
        PROC: begin
          // every filter advances each sample so a later mode switch lands on a settled state
          yl[idx] <= yl_nx;
          ym[idx] <= ym_nx;
          yh[idx] <= yh_nx;
`ifdef SND_DCRM_EN
          dc[idx] <= dc_nx;
`endif
          acc <= acc + contrib;
          idx <= idx + 1'b1;
        end
        MIX: begin
          sound       <= sat;
          sound_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
